// File: rtl/next_pc_unit.sv
// Next-PC generator for the single-cycle MIPS core, plus jump/branch statistics counters.
// Optional feature: define NPC_SAT_CNT_EN to make the counters saturate instead of wrapping.
module next_pc_unit #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IM,
  input  logic [31:0]      OFFSET,
  input  logic [31:0]      PC,
  input  logic [31:0]      RegRT,
  input  logic [31:0]      RegRS,
  output logic [31:0]      NextPC,
  output logic [CNT_W-1:0] unconditional,
  output logic [CNT_W-1:0] conditional,
  output logic [CNT_W-1:0] conditionalsucces
);

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_jump;
  logic        is_jr;
  logic        is_beq;
  logic        is_bne;
  logic        is_syscall;
  logic        is_uncond;
  logic        is_branch;
  logic        regs_equal;
  logic        taken;
  logic [31:0] pc4;
  logic [31:0] boff;
  logic        unused_offset_hi;

  assign op         = IM[31:26];
  assign funct      = IM[5:0];
  assign is_jump    = (op == OP_J) || (op == OP_JAL);
  assign is_jr      = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_syscall = (op == OP_RTYPE) && (funct == FN_SYSCALL);
  assign is_beq     = (op == OP_BEQ);
  assign is_bne     = (op == OP_BNE);
  assign is_uncond  = is_jump || is_jr;
  assign is_branch  = is_beq || is_bne;
  assign regs_equal = (RegRS == RegRT);
  assign taken      = (is_beq && regs_equal) || (is_bne && !regs_equal);

  assign pc4  = PC + 32'd4;
  assign boff = pc4 + {{14{OFFSET[15]}}, OFFSET[15:0], 2'b00};

  // Only the low half of OFFSET carries the branch displacement.
  assign unused_offset_hi = ^OFFSET[31:16];

  // Next-PC selection; sequential by default.
  always_comb begin
    NextPC = pc4;
    if (is_jump) begin
      NextPC = {pc4[31:28], IM[25:0], 2'b00};
    end else if (is_jr) begin
      NextPC = RegRS;
    end else if (is_branch) begin
      NextPC = taken ? boff : pc4;
    end else if (is_syscall && (RegRS == HALT_CODE)) begin
      NextPC = PC;
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt);
`ifdef NPC_SAT_CNT_EN
    bump = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
`else
    bump = cnt + CNT_W'(1);
`endif
  endfunction

  // Statistics counters; reset wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      unconditional     <= '0;
      conditional       <= '0;
      conditionalsucces <= '0;
    end else begin
      if (is_uncond) begin
        unconditional <= bump(unconditional);
      end
      if (is_branch) begin
        conditional <= bump(conditional);
        if (taken) begin
          conditionalsucces <= bump(conditionalsucces);
        end
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: expected NextPC and counter values are queued per driven
// instruction and compared one edge later. Honours NPC_SAT_CNT_EN for the counter model.
module tb_next_pc_unit;

  logic        clk;
  logic        rst;
  logic [31:0] IM;
  logic [31:0] OFFSET;
  logic [31:0] PC;
  logic [31:0] RegRT;
  logic [31:0] RegRS;
  logic [31:0] NextPC;
  logic [15:0] unconditional;
  logic [15:0] conditional;
  logic [15:0] conditionalsucces;

  next_pc_unit #(.CNT_W(16), .HALT_CODE(32'd10)) dut (
    .clk(clk), .rst(rst), .IM(IM), .OFFSET(OFFSET), .PC(PC), .RegRT(RegRT), .RegRS(RegRS),
    .NextPC(NextPC), .unconditional(unconditional), .conditional(conditional),
    .conditionalsucces(conditionalsucces)
  );

  typedef struct packed {
    logic [31:0] im, off, pc, rs, rt, npc;
    logic        r, iu, ic, is;
  } stim_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [15:0] u, c, s;
  } exp_t;

  localparam logic [31:0] I_J     = 32'h0808_4210;
  localparam logic [31:0] I_JAL   = 32'h0FFF_FFFF;
  localparam logic [31:0] I_JR    = 32'h0000_0008;
  localparam logic [31:0] I_BEQ   = 32'h1000_0000;
  localparam logic [31:0] I_BNE   = 32'h1400_0000;
  localparam logic [31:0] I_SYS   = 32'h0000_000C;
  localparam logic [31:0] I_ADD   = 32'h0022_1820;

  exp_t        sb[$];
  string       tags[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mu, mc, ms;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] bump(input logic [15:0] x);
`ifdef NPC_SAT_CNT_EN
    return (x == 16'hFFFF) ? x : x + 16'd1;
`else
    return x + 16'd1;
`endif
  endfunction

  function automatic stim_t mk(input logic [31:0] im, off, pc, rs, rt, npc,
                               input logic r, iu, ic, is);
    mk = '{im: im, off: off, pc: pc, rs: rs, rt: rt, npc: npc, r: r, iu: iu, ic: ic, is: is};
  endfunction

  // Apply one instruction for one edge and queue what the DUT must show afterwards.
  task automatic drive(input stim_t s, input string tag);
    IM = s.im; OFFSET = s.off; PC = s.pc; RegRS = s.rs; RegRT = s.rt; rst = s.r;
    if (s.r) begin
      mu = '0; mc = '0; ms = '0;
    end else begin
      if (s.iu) mu = bump(mu);
      if (s.ic) mc = bump(mc);
      if (s.is) ms = bump(ms);
    end
    sb.push_back('{npc: s.npc, u: mu, c: mc, s: ms});
    tags.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; string t;
    drive(mk(I_J, 0, 0, 0, 0, 32'h0021_0840, 1, 0, 0, 0), "reset");
    e = sb.pop_front(); t = tags.pop_front();
    n_cmp++;
    if (NextPC !== e.npc) begin
      n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
    end
    n_cmp++;
    if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
      n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                        unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
    end
  endtask

  task automatic test_jump();
    stim_t st[$]; exp_t e; string t;
    st = '{mk(I_J, 0, 0, 0, 0, 32'h0021_0840, 0, 1, 0, 0),
           mk(I_J, 0, 0, 0, 0, 32'h0021_0840, 0, 1, 0, 0),
           mk(I_J, 0, 0, 0, 0, 32'h0021_0840, 0, 1, 0, 0),
           mk(I_JAL, 0, 32'h3000_0000, 0, 0, 32'h3FFF_FFFC, 0, 1, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("jump_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  task automatic test_jr();
    stim_t st[$]; exp_t e; string t;
    st = '{mk(I_JR, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 1, 0, 0),
           mk(I_JR, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 1, 0, 0),
           mk(I_JR, 0, 32'h40, 32'h0000_0123, 0, 32'h0000_0123, 0, 1, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("jr_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  task automatic test_bne();
    stim_t st[$]; exp_t e; string t;
    st = '{mk(I_BNE, 32'h0000_FFFE, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, 0, 1, 1),
           mk(I_BNE, 32'h0000_FFFE, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, 0, 1, 1),
           mk(I_BNE, 32'hABCD_0004, 32'h100, 5, 5, 32'h0000_0104, 0, 0, 1, 0),
           mk(I_BNE, 32'hABCD_0004, 32'h100, 6, 5, 32'h0000_0114, 0, 0, 1, 1)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("bne_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  task automatic test_beq();
    stim_t st[$]; exp_t e; string t;
    st = '{mk(I_BEQ, 32'h0000_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0, 1, 1),
           mk(I_BEQ, 32'h0000_FFFF, 0, 32'hFFFF_FFFF, 32'h0, 32'h4, 0, 0, 1, 0)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("beq_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  task automatic test_syscall();
    stim_t st[$]; exp_t e; string t;
    st = '{mk(I_SYS, 0, 0, 32'hA, 0, 32'h0, 0, 0, 0, 0),
           mk(I_SYS, 0, 32'h200, 32'hA, 0, 32'h200, 0, 0, 0, 0),
           mk(I_SYS, 0, 0, 32'h1, 0, 32'h4, 0, 0, 0, 0),
           mk(I_ADD, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("syscall_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  task automatic test_midrun_reset();
    stim_t st[$]; exp_t e; string t;
    st = '{mk(I_J, 0, 0, 0, 0, 32'h0021_0840, 1, 1, 0, 0),
           mk(I_J, 0, 0, 0, 0, 32'h0021_0840, 0, 1, 0, 0),
           mk(I_BEQ, 32'h0000_0002, 32'h10, 3, 3, 32'h0000_001C, 0, 0, 1, 1),
           mk(I_BNE, 32'h0000_0002, 32'h10, 3, 3, 32'h0000_0014, 0, 0, 1, 0)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("midrun_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  // Drive conditional/conditionalsucces up to the top of their range and one step past it.
  task automatic test_wrap();
    stim_t st[$]; exp_t e; string t;
    drive(mk(I_BNE, 32'h0000_FFFE, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 1, 0, 0, 0), "wrap_rst");
    e = sb.pop_front(); t = tags.pop_front();
    n_cmp++;
    if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
      n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                        unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
    end
    rst = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    for (int i = 0; i < 65534; i++) begin
      mc = bump(mc); ms = bump(ms);
    end
    st = '{mk(I_BNE, 32'h0000_FFFE, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, 0, 1, 1),
           mk(I_BNE, 32'h0000_FFFE, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, 0, 1, 1),
           mk(I_BEQ, 32'h0000_FFFE, 0, 32'h1, 0, 32'h4, 0, 0, 1, 0)};
    foreach (st[i]) begin
      drive(st[i], $sformatf("wrap_%0d", i));
      e = sb.pop_front(); t = tags.pop_front();
      n_cmp++;
      if (NextPC !== e.npc) begin
        n_bad++; $display("FAIL %s next_pc got %h want %h", t, NextPC, e.npc);
      end
      n_cmp++;
      if ({unconditional, conditional, conditionalsucces} !== {e.u, e.c, e.s}) begin
        n_bad++; $display("FAIL %s counters got %h/%h/%h want %h/%h/%h", t,
                          unconditional, conditional, conditionalsucces, e.u, e.c, e.s);
      end
    end
  endtask

  initial begin
    rst = 1'b1; IM = '0; OFFSET = '0; PC = '0; RegRT = '0; RegRS = '0;
    mu = '0; mc = '0; ms = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_jump();
    test_jr();
    test_bne();
    test_beq();
    test_syscall();
    test_midrun_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Next-PC generator for the single-cycle MIPS CPU, sitting between the PC register and instruction memory/decoder.
- Decodes the current instruction word and computes the next PC combinationally: sequential, jump, jump-register, conditional branch, or halt-hold.
- Keeps three 16-bit statistics counters: unconditional jumps, conditional branches executed, and conditional branches taken.

Parameters:
CNT_W, 16, width of each statistics counter; must match the counter port widths.
HALT_CODE, 32'd10, syscall service number in RegRS that halts execution.

Ports:
clk  input  1  system clock; counters update on its rising edge
rst  input  1  synchronous, active-high reset
IM  input  32  current instruction word
OFFSET  input  32  branch offset; only OFFSET[15:0] is used, sign-extended internally
PC  input  32  current program counter
RegRT  input  32  value of the rt register
RegRS  input  32  value of the rs register
NextPC  output  32  next program counter (combinational)
unconditional  output  CNT_W  count of executed J/JAL/JR
conditional  output  CNT_W  count of executed BEQ/BNE
conditionalsucces  output  CNT_W  count of taken BEQ/BNE

Behaviour:
- Decode: op=IM[31:26], funct=IM[5:0].
  - J: op=6'h02. JAL: op=6'h03. BEQ: op=6'h04. BNE: op=6'h05.
  - JR: op=0, funct=6'h08. SYSCALL: op=0, funct=6'h0C.
- Fields: pc4 = PC+4, modulo 2^32. boff = sign-extended OFFSET[15:0] shifted left by 2, added to pc4 modulo 2^32. OFFSET[31:16] is ignored.
- NextPC, purely combinational and independent of rst:
  - J/JAL: {pc4[31:28], IM[25:0], 2'b00}.
  - JR: RegRS, used as-is with no alignment masking.
  - BEQ: boff if RegRS==RegRT, else pc4.
  - BNE: boff if RegRS!=RegRT, else pc4.
  - SYSCALL with RegRS==HALT_CODE: PC (hold / halt).
  - SYSCALL with any other RegRS: pc4.
  - Any other instruction: pc4.
- Counters, on each rising clk edge:
  - rst=1: all three counters load 0. Reset has priority over any increment in the same cycle.
  - Otherwise, J/JAL/JR: unconditional += 1.
  - Otherwise, BEQ/BNE: conditional += 1; conditionalsucces also += 1 in the same edge when the branch condition is true.
  - All other instructions, including halting SYSCALL: no counter changes.
- One instruction is counted once per clock edge. An instruction held for N edges counts N times.
- Counters wrap from 2^CNT_W-1 to 0, unless NPC_SAT_CNT_EN is defined.
- Counter outputs come directly from registers. No latency on NextPC.
- A reset asserted mid-run clears the counters at the next edge. NextPC continues to track its inputs.
- Counter state after power-up without reset is X; the bench must apply rst before checking counts.

Optional Feature:
- NPC_SAT_CNT_EN defined: each counter saturates at 2^CNT_W-1 (0xFFFF) and further increments are dropped. conditional and conditionalsucces saturate independently.
- NPC_SAT_CNT_EN undefined: counters wrap modulo 2^CNT_W.

Test Plan:
- PC=0, IM=32'h08084210 (J) -> NextPC=32'h00210840. After rst pulse, hold 3 edges -> unconditional=3, others 0.
- PC=0, IM=32'h00000008 (JR), RegRS=32'hFFFFFFFF -> NextPC=32'hFFFFFFFF; unconditional increments each edge.
- PC=0, IM=32'h14000000 (BNE), RegRS=32'hFFFFFFFF, RegRT=0, OFFSET=32'h0000FFFE -> NextPC=32'hFFFFFFFC. Each edge increments conditional and conditionalsucces by 1.
- PC=0, IM=32'h10000000 (BEQ), RegRS=RegRT=32'hFFFFFFFF, OFFSET=32'h0000FFFF -> NextPC=0, taken. Then RegRT=0 -> NextPC=4; conditional increments, conditionalsucces does not.
- PC=0, IM=32'h0000000C (SYSCALL), RegRS=32'hA -> NextPC=0 with no counter change. RegRS=32'h1 -> NextPC=4.
- Counters nonzero, assert rst for one edge while IM=J -> all counters 0. Preload to 0xFFFF and increment -> 0 without NPC_SAT_CNT_EN, stays 0xFFFF with NPC_SAT_CNT_EN.
